// File: rtl/run_ctrl.sv
// run_ctrl: enable synchroniser, HALTED/RUN/DRAIN/STEP run-control FSM with bounded stepping.
// Cycle/instret counters are built only when RUN_CTRL_COUNTERS_EN is defined; otherwise they read 0.
module run_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int STEP_WIDTH  = 16,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  step_req_i,
  input  logic [STEP_WIDTH-1:0] step_cnt_i,
  input  logic                  fetch_fire_i,
  input  logic                  retire_i,
  input  logic                  pipe_empty_i,
  input  logic                  clr_cnt_i,
  output logic                  stall_o,
  output logic                  halted_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_cnt_o
);

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    w_en_s;
  logic [STEP_WIDTH-1:0]   r_remain;
  logic [STEP_WIDTH-1:0]   w_remain_next;

  // enable is asynchronous to clk; the oldest stage is the only one the FSM may look at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], enable};
  end

  assign w_en_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HALTED;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_next;
      r_remain <= w_remain_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_remain_next = r_remain;
    case (r_state)
      S_HALTED: begin
        if (w_en_s) begin
          w_state_next = S_RUN;
        end else if (step_req_i && (step_cnt_i != '0)) begin
          w_remain_next = step_cnt_i;
          w_state_next  = S_STEP;
        end
      end
      S_RUN: begin
        if (!w_en_s) w_state_next = S_DRAIN;
      end
      S_STEP: begin
        // a resumed run abandons whatever steps were left
        if (w_en_s) begin
          w_state_next  = S_RUN;
          w_remain_next = '0;
        end else if (fetch_fire_i) begin
          w_remain_next = r_remain - STEP_WIDTH'(1);
          if (r_remain == STEP_WIDTH'(1)) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_en_s)            w_state_next = S_RUN;
        else if (pipe_empty_i) w_state_next = S_HALTED;
      end
      default: w_state_next = S_HALTED;
    endcase
  end

  assign stall_o  = (r_state == S_HALTED) || (r_state == S_DRAIN);
  assign halted_o = (r_state == S_HALTED);

`ifdef RUN_CTRL_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_instret_cnt;
  logic                 w_active;

  assign w_active = (r_state == S_RUN) || (r_state == S_STEP);

  // clear beats increment; both counters wrap naturally at 2^CNT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_active) r_cycle_cnt   <= r_cycle_cnt + CNT_WIDTH'(1);
      if (retire_i) r_instret_cnt <= r_instret_cnt + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt_o   = r_cycle_cnt;
  assign instret_cnt_o = r_instret_cnt;
`else
  logic w_unused_cnt;

  assign w_unused_cnt  = clr_cnt_i ^ retire_i;
  assign cycle_cnt_o   = '0;
  assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed + random stimulus for run_ctrl, checked each cycle by a scoreboard
// fed from a mode/step-budget reference model with an enable-latency history queue.
`timescale 1ns/1ps
module tb_run_ctrl;
  localparam int SYNC = 2;
  localparam int SW   = 16;
  localparam int CW   = 8;
`ifdef RUN_CTRL_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          step_req_i;
  logic [SW-1:0] step_cnt_i;
  logic          fetch_fire_i;
  logic          retire_i;
  logic          pipe_empty_i;
  logic          clr_cnt_i;
  logic          stall_o;
  logic          halted_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [CW-1:0] instret_cnt_o;

  always #5 clk = ~clk;

  run_ctrl #(.SYNC_STAGES(SYNC), .STEP_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_req_i(step_req_i),
    .step_cnt_i(step_cnt_i), .fetch_fire_i(fetch_fire_i), .retire_i(retire_i),
    .pipe_empty_i(pipe_empty_i), .clr_cnt_i(clr_cnt_i), .stall_o(stall_o),
    .halted_o(halted_o), .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
  );

  typedef struct {
    bit stall;
    bit halted;
    int cyc;
    int ret;
  } exp_t;

  typedef enum {M_HALT, M_RUN, M_DRAIN, M_STEP} mode_e;

  exp_t  sb_q[$];
  bit    en_hist[$];
  mode_e m_mode;
  int    m_left;
  int    m_cyc;
  int    m_ret;
  int    total = 0;
  int    bad = 0;
  int    txn = 0;
  int    fire_acc = 0;

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HALT;
    m_left = 0;
    m_cyc  = 0;
    m_ret  = 0;
    en_hist.delete();
    for (int i = 0; i < SYNC; i++) en_hist.push_back(1'b0);
  endtask

  // Predicts the outputs after the coming rising edge from the inputs now applied.
  task automatic model_edge();
    exp_t e;
    bit   en_seen;
    if (!rst_n) begin
      model_reset();
    end else begin
      en_seen = en_hist.pop_front();
      en_hist.push_back(enable);
      if (CNT_ON) begin
        if (clr_cnt_i) begin
          m_cyc = 0;
          m_ret = 0;
        end else begin
          if (m_mode == M_RUN || m_mode == M_STEP) m_cyc = (m_cyc + 1) % (1 << CW);
          if (retire_i) m_ret = (m_ret + 1) % (1 << CW);
        end
      end
      case (m_mode)
        M_HALT:
          if (en_seen) m_mode = M_RUN;
          else if (step_req_i && step_cnt_i != 0) begin
            m_left = int'(step_cnt_i);
            m_mode = M_STEP;
          end
        M_RUN:   if (!en_seen) m_mode = M_DRAIN;
        M_STEP:
          if (en_seen) begin
            m_mode = M_RUN;
            m_left = 0;
          end else if (fetch_fire_i) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_DRAIN;
          end
        M_DRAIN:
          if (en_seen) m_mode = M_RUN;
          else if (pipe_empty_i) m_mode = M_HALT;
        default: m_mode = M_HALT;
      endcase
    end
    e.stall  = (m_mode == M_HALT) || (m_mode == M_DRAIN);
    e.halted = (m_mode == M_HALT);
    e.cyc    = m_cyc;
    e.ret    = m_ret;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    if (rst_n && fetch_fire_i && !stall_o) fire_acc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d stall=%0b halted=%0b cyc=%0d ret=%0d", txn, stall_o, halted_o,
                 cycle_cnt_o, instret_cnt_o);
        chk("sb_stall",  int'(stall_o),       int'(e.stall));
        chk("sb_halted", int'(halted_o),      int'(e.halted));
        chk("sb_cycle",  int'(cycle_cnt_o),   e.cyc);
        chk("sb_instret", int'(instret_cnt_o), e.ret);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; enable = 1'b0; step_req_i = 1'b0; step_cnt_i = '0;
    fetch_fire_i = 1'b0; retire_i = 1'b0; pipe_empty_i = 1'b1; clr_cnt_i = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("rst_stall", int'(stall_o), 1);
    chk("rst_halted", int'(halted_o), 1);
    chk("rst_cycle", int'(cycle_cnt_o), 0);
    chk("rst_instret", int'(instret_cnt_o), 0);
    rst_n = 1'b1;

    // enable rises: 3-edge latency to RUN
    enable = 1'b1;
    tick(); tick();
    chk("en_lat_e2_stall", int'(stall_o), 1);
    tick();
    chk("en_lat_e3_stall", int'(stall_o), 0);
    chk("en_lat_e3_halted", int'(halted_o), 0);
    for (int i = 0; i < 10; i++) begin
      retire_i = 1'($urandom_range(0, 1));
      tick();
    end

    // enable falls with pipeline busy for 5 cycles, retiring while draining
    enable = 1'b0; pipe_empty_i = 1'b0; retire_i = 1'b1;
    tick(); tick(); tick();
    chk("drain_e3_stall", int'(stall_o), 1);
    tick(); tick();
    chk("drain_e5_halted", int'(halted_o), 0);
    pipe_empty_i = 1'b1;
    tick();
    chk("drain_e6_halted", int'(halted_o), 1);
    retire_i = 1'b0;

    // 3-instruction step with fetch offered every cycle
    fire_acc = 0;
    fetch_fire_i = 1'b1; step_req_i = 1'b1; step_cnt_i = SW'(3);
    tick();
    step_req_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("step3_fires", fire_acc, 3);
    chk("step3_halted", int'(halted_o), 1);
    step_req_i = 1'b1; step_cnt_i = '0;
    tick();
    step_req_i = 1'b0;
    tick();
    chk("step0_stall", int'(stall_o), 1);

    // step of 10 interrupted by enable
    fetch_fire_i = 1'b0; step_req_i = 1'b1; step_cnt_i = SW'(10);
    tick();
    step_req_i = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("step_to_run_stall", int'(stall_o), 0);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("step_to_run_halt", int'(halted_o), 1);

    // counter wrap and clear priority
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0; retire_i = 1'b1; enable = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    clr_cnt_i = 1'b1;
    tick();
    clr_cnt_i = 1'b0;
    for (int i = 0; i < 258; i++) tick();
    retire_i = 1'b0; enable = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // reset in the middle of an 8-step with 5 remaining
    fetch_fire_i = 1'b1; step_req_i = 1'b1; step_cnt_i = SW'(8);
    tick();
    step_req_i = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", int'(stall_o), 1);
    chk("midrst_halted", int'(halted_o), 1);
    chk("midrst_cycle", int'(cycle_cnt_o), 0);
    chk("midrst_instret", int'(instret_cnt_o), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("postrst_halted", int'(halted_o), 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      step_req_i   = ($urandom_range(0, 7) == 0);
      step_cnt_i   = SW'($urandom_range(0, 6));
      fetch_fire_i = 1'($urandom_range(0, 1));
      retire_i     = 1'($urandom_range(0, 1));
      pipe_empty_i = ($urandom_range(0, 2) != 0);
      clr_cnt_i    = ($urandom_range(0, 63) == 0);
      rst_n        = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; step_req_i = 1'b0; clr_cnt_i = 1'b0;
    tick();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
